ahb_slave_mem: RTL and testbench
================================

// Module: ahb_slave_mem
// PURPOSE
//  AHB-Lite responder for the ahb_master bus interface: word-organised SRAM slave, selected by hsel code.
//  Decodes address phase, inserts programmable wait states, performs byte/half/word writes and word reads.
//  Returns hready/hresp/hrdata to the master. Sits between the master's bus outputs and its hready/hresp/hrdata inputs.
// PARAMETERS
//  SLAVE_ID    2'b01  hsel code this slave responds to
//  ADDR_W      8      word-address width; memory depth = 2**ADDR_W 32-bit words
//  WAIT_STATES 1      hready-low cycles inserted per data phase (0..15)
// PORTS
//  clk     in   1   bus clock, all state on rising edge
//  hreset  in   1   asynchronous active-high reset
//  hsel    in   2   slave select code; match = (hsel==SLAVE_ID)
//  haddr   in   32  byte address (address phase)
//  htrans  in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite  in   1   1 write, 0 read
//  hsize   in   3   0 byte, 1 half, 2 word; others illegal
//  hburst  in   3   burst type; informational only, each beat decoded independently
//  hwdata  in   32  write data (data phase)
//  hrdata  out  32  read data, valid when hready=1 in a read data phase
//  hready  out  1   1 = transfer complete / slave ready
//  hresp   out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset (async, hreset=1): hready=1, hresp=0, hrdata=0, state IDLE, wait counter 0, captured addr/ctrl 0. Memory not cleared.
//  Address phase accepted at rising edge when hready=1 && hsel==SLAVE_ID && htrans[1]==1; capture haddr, hwrite, hsize.
//  IDLE/BUSY htrans or non-matching hsel: no access; next cycle hready=1, hresp=0 (zero-wait OKAY).
//  States: IDLE -> WAIT (WAIT_STATES>0) or DATA (WAIT_STATES=0); WAIT -> DATA after WAIT_STATES cycles;
//    DATA -> IDLE, or next access (WAIT/DATA/ERR1) if a new address phase is accepted in the same cycle (pipelined).
//  WAIT: hready=0, hresp=0, counter decrements from WAIT_STATES. DATA: hready=1, hresp=0.
//  Latency: read/write completes WAIT_STATES+1 cycles after address-phase edge; back-to-back throughput 1 per WAIT_STATES+1 cycles.
//  Write: hwdata sampled at the DATA-cycle edge; lanes by haddr[1:0]/hsize: byte -> lane haddr[1:0], half -> lanes haddr[1]*2+{0,1}, word -> all.
//  Read: hrdata = mem[haddr[ADDR_W+1:2]] driven during DATA; hrdata holds last value otherwise.
//  Read immediately after write to same word: bypass, return newly merged data.
//  Word index = haddr[ADDR_W+1:2]; bits above ignored unless AHB_SLAVE_ERR_EN.
//  ERROR response (two-cycle, per AHB): ERR1 hready=0 hresp=1; ERR2 hready=1 hresp=1; no memory update; ERR2 -> IDLE
//    (address phase offered during ERR2 accepted normally).
//  Reset mid-transfer: abort immediately to reset values; pending write discarded.
// CONFIGURATION
//  AHB_SLAVE_ERR_EN defined: ERROR response (no wait states) for hsize>2, misalignment (half with haddr[0]=1,
//    word with haddr[1:0]!=0), or any haddr bit above ADDR_W+1 set.
//  AHB_SLAVE_ERR_EN undefined: hresp tied 0; hsize>2 treated as word; low address bits ignored for alignment
//    (half uses haddr[1], word uses all lanes); upper address bits ignored (wraps modulo depth); ERR states absent.
// TESTING
//  WAIT_STATES=1: write word 0xDEADBEEF @0x10, read @0x10 -> hready low 1 cycle each, hrdata=0xDEADBEEF, hresp=0.
//  Byte write 0xAA @0x11 over word 0x00000000 -> read @0x10 returns 0x0000AA00.
//  hsel=2'b10 (no match), htrans=NONSEQ -> hready stays 1, memory unchanged, hresp=0.
//  ERR_EN: read @0x400 with ADDR_W=8 -> cycle1 hready=0 hresp=1, cycle2 hready=1 hresp=1; no ERR_EN -> reads word 0x00.
//  WAIT_STATES=0 back-to-back write @0x20 then read @0x20 -> read returns written data via bypass, 1 cycle each.
//  Assert hreset during WAIT of a write -> hready=1 hresp=0 immediately; subsequent read shows old data.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem
//   AHB-Lite SRAM responder. Accepts an address phase when it is selected
//   (hsel == SLAVE_ID) by a NONSEQ/SEQ transfer while hready is high. It then
//   holds hready low for WAIT_STATES cycles and completes the transfer in a
//   single DATA cycle. Writes merge byte lanes into a 32-bit word memory.
//   Reads return a whole word. A new address phase can overlap the current
//   DATA cycle.
//
//   Optional feature, macro AHB_SLAVE_ERR_EN:
//     When defined, the slave returns a two-cycle ERROR response for any of:
//       - hsize > 2
//       - a misaligned half or word access
//       - any haddr bit above ADDR_W+1 set
//     When undefined:
//       - hresp is always 0
//       - hsize > 2 is treated as a word access
//       - upper address bits wrap modulo the memory depth
//
//   Ports
//     clk     in   1   bus clock, rising edge
//     hreset  in   1   asynchronous active-high reset
//     hsel    in   2   slave select code
//     haddr   in  32   byte address (address phase)
//     htrans  in   2   IDLE/BUSY/NONSEQ/SEQ
//     hwrite  in   1   1 = write
//     hsize   in   3   0 byte, 1 half, 2 word
//     hburst  in   3   ignored; every beat is decoded on its own
//     hwdata  in  32   write data (data phase)
//     hrdata  out 32   read data, valid in a read DATA cycle, held otherwise
//     hready  out  1   transfer done / slave ready
//     hresp   out  1   0 OKAY, 1 ERROR
module ahb_slave_mem #(
  parameter logic [1:0]  SLAVE_ID    = 2'b01,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        hreset,
  input  logic [1:0]  hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
`ifdef AHB_SLAVE_ERR_EN
    , S_ERR1,
    S_ERR2
`endif
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        lane_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic              hready_q;
  logic              hresp_q;
  logic [31:0]       hrdata_q;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              wr_en;
  logic              bypass;
  logic [ADDR_W-1:0] idx_d;
  logic [3:0]        be;
  logic [31:0]       old_word;
  logic [31:0]       merged;
  logic [31:0]       rd_word_d;
  logic              unused_inputs;

  assign accept = hready_q && (hsel == SLAVE_ID) && htrans[1];
  assign idx_d  = haddr[ADDR_W+1:2];
  assign wr_en  = (state_q == S_DATA) && write_q;

  // Byte-lane enables of the captured transfer. Half accesses select their
  // lane pair by addr[1] only, so addr[0] never steers a half write.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be[lane_q] = 1'b1;
      3'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Merged word produced by the write that commits at the end of this cycle.
  always_comb begin
    old_word = mem[idx_q];
    merged   = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = hwdata[8*b +: 8];
    end
  end

  // With zero wait states a read's data is registered at the same edge
  // that commits the previous write. A same-word hit must therefore see
  // the merged word, not the stale array contents.
  assign bypass    = wr_en && (idx_q == idx_d);
  assign rd_word_d = bypass ? merged : mem[idx_d];

`ifdef AHB_SLAVE_ERR_EN
  logic err_d;
  always_comb begin
    err_d = (hsize > 3'd2)
         || ((hsize == 3'd1) && haddr[0])
         || ((hsize == 3'd2) && (haddr[1:0] != 2'b00))
         || ((haddr >> (ADDR_W + 2)) != 32'd0);
  end
`endif

  // NOTE: the storage array is deliberately left out of reset. Contents
  // survive hreset, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx_q] <= merged;
  end

  always_ff @(posedge clk or posedge hreset) begin
    if (hreset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q  <= S_DATA;
            cnt_q    <= '0;
            hready_q <= 1'b1;
            if (!write_q) hrdata_q <= mem[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`ifdef AHB_SLAVE_ERR_EN
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
`endif
        // IDLE, DATA and ERR2 all drive hready high, so each of them may
        // take a new address phase in the same cycle.
        default: begin
          // NOTE: non-blocking assignments let later lines override these
          // defaults, and every read sees the pre-edge register values.
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (accept) begin
            idx_q   <= idx_d;
            lane_q  <= haddr[1:0];
            size_q  <= hsize;
            write_q <= hwrite;
`ifdef AHB_SLAVE_ERR_EN
            if (err_d) begin
              state_q  <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else
`endif
            if (WS == 4'd0) begin
              state_q <= S_DATA;
              if (!hwrite) hrdata_q <= rd_word_d;
            end else begin
              state_q  <= S_WAIT;
              cnt_q    <= WS;
              hready_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign hrdata = hrdata_q;
  assign hready = hready_q;
  assign hresp  = hresp_q;

  // Bits the decoder does not need (burst type, htrans[0], upper address).
  assign unused_inputs = ^{hburst, htrans[0], haddr};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Testbench for ahb_slave_mem.
// Two instances sit on one shared bus: WAIT_STATES=1 (index 0) and
// WAIT_STATES=0 (index 1). Only the instance selected by 'cur' sees hsel.
// The other always sees 2'b00, and the outputs are multiplexed by 'cur'.
// A pipelined master pushes one expected response per accepted address
// phase. A monitor pops and compares that response when the data phase
// ends (hready high).
module tb_ahb_slave_mem;

  localparam int DEPTH = 256;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic        nonseq;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          waits;
    logic        resp;
    logic        chk;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        hreset;
  logic [1:0]  hsel_drv;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  int          cur;

  logic [1:0]  hsel_a, hsel_b;
  logic [31:0] hrdata_a, hrdata_b, hrdata_m;
  logic        hready_a, hready_b, hready_m;
  logic        hresp_a, hresp_b, hresp_m;

  assign hsel_a   = (cur == 0) ? hsel_drv : 2'b00;
  assign hsel_b   = (cur == 1) ? hsel_drv : 2'b00;
  assign hrdata_m = (cur == 0) ? hrdata_a : hrdata_b;
  assign hready_m = (cur == 0) ? hready_a : hready_b;
  assign hresp_m  = (cur == 0) ? hresp_a  : hresp_b;

  ahb_slave_mem #(.SLAVE_ID(2'b01), .ADDR_W(8), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .hreset(hreset), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata_a), .hready(hready_a), .hresp(hresp_a)
  );

  ahb_slave_mem #(.SLAVE_ID(2'b01), .ADDR_W(8), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .hreset(hreset), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata_b), .hready(hready_b), .hresp(hresp_b)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          abort   = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] mm [2][DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic txn_t mk(input logic [1:0] sel, input logic [31:0] addr, input logic wr,
                              input logic [2:0] size, input logic [31:0] wdata);
    txn_t t;
    t.sel = sel; t.addr = addr; t.nonseq = 1'b1; t.wr = wr; t.size = size; t.wdata = wdata;
    return t;
  endfunction

  // Reference model: expected response of instance k to one accepted address phase.
  task automatic model_step(input int k, input txn_t t, output exp_t e);
    int          idx;
    logic [31:0] mask;
    logic        err;
    e.waits = 0; e.resp = 1'b0; e.chk = 1'b0; e.rdata = '0;
    if (t.sel == 2'b01 && t.nonseq) begin
      idx = int'((t.addr >> 2) % DEPTH);
      err = 1'b0;
`ifdef AHB_SLAVE_ERR_EN
      err = (t.size > 3'd2) || (t.size == 3'd1 && t.addr[0]) ||
            (t.size == 3'd2 && t.addr[1:0] != 2'b00) || (t.addr >= 32'(4 * DEPTH));
`endif
      if (err) begin
        e.waits = 1;
        e.resp  = 1'b1;
      end else begin
        e.waits = (k == 0) ? 1 : 0;
        if (t.wr) begin
          if (t.size == 3'd0)      mask = 32'hFF << (8 * t.addr[1:0]);
          else if (t.size == 3'd1) mask = 32'hFFFF << (16 * t.addr[1]);
          else                     mask = 32'hFFFF_FFFF;
          mm[k][idx] = (mm[k][idx] & ~mask) | (t.wdata & mask);
        end else begin
          e.chk   = 1'b1;
          e.rdata = mm[k][idx];
        end
      end
    end
  endtask

  // Call at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue(input txn_t t);
    exp_t e;
    logic rdy;
    int   guard;
    if (abort) return;
    hsel_drv = t.sel; haddr = t.addr; htrans = t.nonseq ? 2'b10 : 2'b00;
    hwrite = t.wr; hsize = t.size; hburst = 3'($urandom_range(7));
    guard = 0;
    forever begin
      @(negedge clk);
      rdy = hready_m;
      @(posedge clk);
      if (rdy) break;
      guard++;
      if (guard > 64) begin
        n_tests++;
        n_fail++;
        $display("FAIL issue_timeout: hready low for %0d cycles, expected high within 64", guard);
        abort = 1'b1;
        hsel_drv = 2'b00; htrans = 2'b00;
        return;
      end
    end
    model_step(cur, t, e);
    exp_q.push_back(e);
    #1;
    hwdata = t.wdata;
    hsel_drv = 2'b00; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic settle();
    int guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (exp_q.size() != 0 && guard < 32);
    #1;
  endtask

  // Monitor: compares each completed data phase with the scoreboard head.
  initial begin : monitor
    int   waits = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (hreset) begin
        waits = 0;
      end else if (exp_q.size() > 0) begin
        if (!hready_m) begin
          waits++;
          check("hresp_while_stalled", hresp_m, exp_q[0].resp);
        end else begin
          e = exp_q.pop_front();
          check("wait_states", waits, e.waits);
          check("hresp_at_completion", hresp_m, e.resp);
          if (e.chk) check("hrdata", hrdata_m, e.rdata);
          waits = 0;
        end
      end
    end
  end

  task automatic test_instance();
    txn_t        t;
    logic [31:0] d, old;
    int          w, lane;
    logic [21:0] up;
    for (int i = 0; i < 16; i++) issue(mk(2'b01, 32'(i * 4), 1'b1, 3'd2, 32'h0));
    issue(mk(2'b01, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF));
    issue(mk(2'b01, 32'h10, 1'b0, 3'd2, 32'h0));
    settle();
    check("hold_deadbeef", hrdata_m, 32'hDEADBEEF);
    issue(mk(2'b01, 32'h10, 1'b1, 3'd2, 32'h0));
    issue(mk(2'b01, 32'h11, 1'b1, 3'd0, 32'h0000AA00));
    issue(mk(2'b01, 32'h10, 1'b0, 3'd2, 32'h0));
    settle();
    check("byte_lane_1", hrdata_m, 32'h0000AA00);
    issue(mk(2'b10, 32'h10, 1'b1, 3'd2, 32'h12345678));
    issue(mk(2'b01, 32'h10, 1'b0, 3'd2, 32'h0));
    settle();
    check("nomatch_no_write", hrdata_m, 32'h0000AA00);
    issue(mk(2'b01, 32'h400, 1'b0, 3'd2, 32'h0));
    settle();
`ifdef AHB_SLAVE_ERR_EN
    check("read_0x400_hold", hrdata_m, 32'h0000AA00);
`else
    check("read_0x400_wrap", hrdata_m, 32'h0);
`endif
    d = $urandom;
    issue(mk(2'b01, 32'h20, 1'b1, 3'd2, d));
    issue(mk(2'b01, 32'h20, 1'b0, 3'd2, 32'h0));
    settle();
    check("raw_same_word", hrdata_m, d);

    for (int i = 0; i < 150; i++) begin
      w    = $urandom_range(15);
      lane = $urandom_range(3);
      up   = ($urandom_range(7) == 0) ? 22'($urandom_range(4194303, 1)) : 22'h0;
      t.addr   = {up, 4'b0000, 4'(w), 2'(lane)};
      t.sel    = ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'b01;
      t.nonseq = ($urandom_range(7) != 0);
      t.wr     = 1'($urandom_range(1));
      t.size   = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(2));
      t.wdata  = $urandom;
      issue(t);
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
    end
    settle();

    // Reset while a write is in flight: the write must be discarded.
    old = mm[cur][12];
    issue(mk(2'b01, 32'h30, 1'b1, 3'd2, 32'hCAFEF00D));
    @(negedge clk);
    #2 hreset = 1'b1;
    #1;
    check("midrst_hready", hready_m, 1'b1);
    check("midrst_hresp", hresp_m, 1'b0);
    check("midrst_hrdata", hrdata_m, 32'h0);
    exp_q.delete();
    mm[cur][12] = old;
    @(negedge clk);
    #2 hreset = 1'b0;
    @(posedge clk);
    #1;
    issue(mk(2'b01, 32'h30, 1'b0, 3'd2, 32'h0));
    settle();
    check("after_rst_old_data", hrdata_m, old);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    hreset = 1'b1; cur = 0;
    hsel_drv = 2'b00; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hready_ws1", hready_a, 1'b1);
    check("rst_hresp_ws1", hresp_a, 1'b0);
    check("rst_hrdata_ws1", hrdata_a, 32'h0);
    check("rst_hready_ws0", hready_b, 1'b1);
    check("rst_hresp_ws0", hresp_b, 1'b0);
    check("rst_hrdata_ws0", hrdata_b, 32'h0);
    @(negedge clk);
    hreset = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      cur = k;
      test_instance();
    end
    settle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
